// File: rtl/roll_scheduler.sv
// Dice-roll sequencer: issues decelerating step enables to an external LFSR,
// latches the final roll and keeps a small browsable history of results.
module roll_scheduler #(
    parameter int STAGE_LEN  = 100000000,
    parameter int BASE_TICK  = STAGE_LEN >> 5,
    parameter int NUM_STAGES = 5,
    parameter int HIST_DEPTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic                              i_prev,
    input  logic [3:0]                        i_rand,
    output logic                              o_step,
    output logic [3:0]                        o_value,
    output logic                              o_busy,
    output logic [2:0]                        o_stage,
    output logic                              o_done,
    output logic [$clog2(HIST_DEPTH)-1:0]     o_hist_idx,
    output logic [$clog2(HIST_DEPTH+1)-1:0]   o_hist_count
);

    localparam int CNT_W = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;
    localparam int IDX_W = $clog2(HIST_DEPTH);
    localparam int HCW   = $clog2(HIST_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROLL,
        S_DONE,
        S_HIST
    } state_t;

    state_t             state, next_state;
    logic [2:0]         stage;
    logic [CNT_W-1:0]   stage_cnt;
    logic [CNT_W-1:0]   tick_cnt;
    logic [CNT_W-1:0]   period_m1;
    logic               tick_end;
    logic               stage_end;
    logic               last_stage;
    logic               step_d;
    logic [3:0]         value_q;
    logic [3:0]         hist [HIST_DEPTH];
    logic [IDX_W-1:0]   wr_ptr;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   rd_ptr;
    logic [HCW-1:0]     hist_count;

    // Step period doubles every stage; modular subtraction keeps a full-width
    // period (BASE_TICK<<stage == 2**CNT_W) decoding correctly as all-ones.
    assign period_m1  = (CNT_W'(BASE_TICK) << stage) - CNT_W'(1);
    assign tick_end   = (tick_cnt == period_m1);
    assign stage_end  = (stage_cnt == CNT_W'(STAGE_LEN - 1));
    assign last_stage = (stage == 3'(NUM_STAGES - 1));
    assign rd_ptr     = wr_ptr - IDX_W'(1) - idx;

    assign o_hist_idx   = idx;
    assign o_hist_count = hist_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        next_state = state;
        o_step     = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_stage    = '0;
        o_value    = value_q;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    next_state = S_ROLL;
                end else if (i_prev && hist_count != '0) begin
                    next_state = S_HIST;
                end
            end
            S_ROLL: begin
                o_busy  = 1'b1;
                o_stage = stage;
                o_step  = tick_end;
                if (!i_start && stage_end && last_stage) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                o_done     = 1'b1;
                next_state = S_IDLE;
            end
            S_HIST: begin
                o_value = hist[rd_ptr];
                if (i_start) begin
                    next_state = S_ROLL;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Counters rest at zero outside a roll, so entry from any state starts clean.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage     <= '0;
            stage_cnt <= '0;
            tick_cnt  <= '0;
        end else if (state != S_ROLL || i_start) begin
            stage     <= '0;
            stage_cnt <= '0;
            tick_cnt  <= '0;
        end else if (stage_end) begin
            stage     <= stage + 3'd1;
            stage_cnt <= '0;
            tick_cnt  <= '0;
        end else begin
            stage_cnt <= stage_cnt + CNT_W'(1);
            tick_cnt  <= tick_end ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // The LFSR advances on the step edge, so its new value is taken a cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_d  <= 1'b0;
            value_q <= '0;
        end else begin
            step_d <= o_step;
            if (state == S_DONE || (state == S_ROLL && step_d)) begin
                value_q <= i_rand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the history array is reset explicitly; it is tiny and must read 0.
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
            wr_ptr     <= '0;
            hist_count <= '0;
        end else if (state == S_DONE) begin
            hist[wr_ptr] <= i_rand;
            wr_ptr       <= wr_ptr + IDX_W'(1);
            if (hist_count != HCW'(HIST_DEPTH)) begin
                hist_count <= hist_count + HCW'(1);
            end
        end
    end

    // Browse offset only lives in S_HIST; it wraps over the valid entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx <= '0;
        end else if (state == S_HIST && !i_start) begin
            if (i_prev) begin
                idx <= (HCW'(idx) == hist_count - HCW'(1)) ? '0 : idx + IDX_W'(1);
            end
        end else begin
            idx <= '0;
        end
    end

endmodule

// File: tb/tb_roll_scheduler.sv
// Randomised scoreboard bench for roll_scheduler: step/done events are predicted
// from the stage/period arithmetic and a bench-owned 4-bit LFSR.
module tb_roll_scheduler;

    localparam int SL       = 64;
    localparam int BT       = 2;
    localparam int NS       = 5;
    localparam int HD       = 4;
    localparam int ROLL_LEN = SL * NS;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_start = 1'b0;
    logic       i_prev  = 1'b0;
    logic [3:0] i_rand;
    logic       o_step;
    logic [3:0] o_value;
    logic       o_busy;
    logic [2:0] o_stage;
    logic       o_done;
    logic [1:0] o_hist_idx;
    logic [2:0] o_hist_count;

    always #5 i_clk = ~i_clk;

    roll_scheduler #(
        .STAGE_LEN (SL),
        .BASE_TICK (BT),
        .NUM_STAGES(NS),
        .HIST_DEPTH(HD)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_prev      (i_prev),
        .i_rand      (i_rand),
        .o_step      (o_step),
        .o_value     (o_value),
        .o_busy      (o_busy),
        .o_stage     (o_stage),
        .o_done      (o_done),
        .o_hist_idx  (o_hist_idx),
        .o_hist_count(o_hist_count)
    );

    initial begin
        if ((BT << (NS - 1)) > SL) begin
            $display("FAIL param_rule: BASE_TICK<<(NUM_STAGES-1)=%0d exceeds STAGE_LEN=%0d",
                     BT << (NS - 1), SL);
            $fatal(1);
        end
    end

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic logic [3:0] lfsr_adv(input logic [3:0] s, input int n);
        logic [3:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = lfsr_next(r);
        return r;
    endfunction

    // Roll cycle n (1-based): stage k = (n-1)/SL, step period BT<<k within the stage.
    function automatic bit step_at(input int n);
        int w, k;
        w = (n - 1) % SL;
        k = (n - 1) / SL;
        return ((w + 1) % (BT << k)) == 0;
    endfunction

    function automatic int steps_upto(input int c);
        int s;
        s = 0;
        for (int n = 1; n <= c; n++) if (step_at(n)) s++;
        return s;
    endfunction

    // Upstream clock-enabled LFSR, seeded 3.
    logic [3:0] lfsr = 4'd3;
    assign i_rand = lfsr;
    always @(posedge i_clk) if (o_step) lfsr <= lfsr_next(lfsr);

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int pre;
        int val;
        int cnt;
    } done_t;

    int         step_q[$];
    done_t      done_q[$];
    logic [3:0] hist_q[$];
    logic [3:0] model_lfsr = 4'd3;
    int         roll_base   = 0;
    bit         roll_active = 1'b0;
    int         step_seen   = 0;
    int         checks      = 0;
    int         errors      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 5)) tick();
    endtask

    function automatic int hist_cnt();
        return (hist_q.size() < HD) ? hist_q.size() : HD;
    endfunction

    task automatic begin_roll(input bit with_prev);
        int    p;
        int    total;
        done_t d;
        p     = cyc;
        total = steps_upto(ROLL_LEN);
        for (int n = 1; n <= ROLL_LEN; n++) if (step_at(n)) step_q.push_back(p + n);
        d.cyc = p + ROLL_LEN + 1;
        d.pre = int'(lfsr_adv(model_lfsr, total - 1));
        d.val = int'(lfsr_adv(model_lfsr, total));
        d.cnt = (hist_q.size() + 1 < HD) ? hist_q.size() + 1 : HD;
        done_q.push_back(d);
        i_start = 1'b1;
        i_prev  = with_prev;
        tick();
        i_start     = 1'b0;
        i_prev      = 1'b0;
        roll_base   = p;
        roll_active = 1'b1;
    endtask

    // Drop predictions beyond cycle c of the current roll (restart keeps the
    // step decoded in cycle c; reset kills it).
    task automatic abort_roll(input int c, input bit by_reset);
        int last;
        last = by_reset ? c - 1 : c;
        while (step_q.size() > 0 && step_q[$] > roll_base + last) step_q.delete(step_q.size() - 1);
        if (done_q.size() > 0) done_q.delete(done_q.size() - 1);
        model_lfsr = lfsr_adv(model_lfsr, steps_upto(last));
    endtask

    task automatic finish_roll(input bit prev_in_done);
        wait_until(roll_base + ROLL_LEN + 1);
        i_prev = prev_in_done;
        tick();
        i_prev = 1'b0;
        tick();
        roll_active = 1'b0;
        model_lfsr  = lfsr_adv(model_lfsr, steps_upto(ROLL_LEN));
        hist_q.push_back(model_lfsr);
    endtask

    task automatic browse_step(input int exp_idx);
        i_prev = 1'b1;
        tick();
        i_prev = 1'b0;
        check("browse_idx", o_hist_idx, exp_idx);
        check("browse_value", o_value, hist_q[hist_q.size() - 1 - exp_idx]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_value"}, o_value, 0);
        check({tag, "_step"}, o_step, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_stage"}, o_stage, 0);
        check({tag, "_hist_idx"}, o_hist_idx, 0);
        check({tag, "_hist_count"}, o_hist_count, 0);
    endtask

    // Monitor: consumes predictions whenever the DUT presents a step or done.
    initial begin : monitor
        done_t cur;
        bit    post;
        int    exp_c, n, eb, es;
        post = 1'b0;
        cur  = '{default: 0};
        forever begin
            @(negedge i_clk);
            if (post) begin
                check("done_value", o_value, cur.val);
                check("done_hist_count", o_hist_count, cur.cnt);
                post = 1'b0;
            end
            if (o_step) begin
                step_seen++;
                if (step_q.size() > 0) exp_c = step_q.pop_front();
                else exp_c = -1;
                check("step_cycle", cyc, exp_c);
            end
            if (o_done) begin
                if (done_q.size() > 0) cur = done_q.pop_front();
                else cur = '{default: -1};
                check("done_cycle", cyc, cur.cyc);
                check("done_live_value", o_value, cur.pre);
                post = 1'b1;
            end
            if (roll_active) begin
                n  = cyc - roll_base;
                eb = (n >= 1 && n <= ROLL_LEN) ? 1 : 0;
                es = (eb != 0) ? (n - 1) / SL : 0;
                check("busy", o_busy, eb);
                check("stage", o_stage, es);
            end
        end
    end

    initial begin : stimulus
        int snap;
        int c;
        #1 i_rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("in_reset");
        i_rst_n = 1'b1;
        tick();
        check_all_zero("after_reset");

        // Roll 1: plain full roll.
        snap = step_seen;
        begin_roll(1'b0);
        check("busy_after_start", o_busy, 1);
        finish_roll(1'b0);
        check("steps_per_roll", step_seen - snap, 62);
        check("hist_count_one", o_hist_count, 1);

        // Roll 2: restart at roll cycle 100, then run to completion.
        idle_gap();
        begin_roll(1'b0);
        wait_until(roll_base + 100);
        abort_roll(100, 1'b0);
        begin_roll(1'b0);
        check("restart_stage", o_stage, 0);
        check("restart_no_push", o_hist_count, 1);
        finish_roll(1'b0);

        // Roll 3: start and prev together, prev mid-roll, prev in the done cycle.
        idle_gap();
        begin_roll(1'b1);
        check("start_beats_prev", o_busy, 1);
        wait_until(roll_base + $urandom_range(10, 300));
        i_prev = 1'b1;
        tick();
        i_prev = 1'b0;
        check("prev_in_roll_idx", o_hist_idx, 0);
        finish_roll(1'b1);
        check("prev_in_done_idx", o_hist_idx, 0);
        for (int k = 0; k < 4; k++) browse_step(k % hist_cnt());

        // Roll 4 from browsing: display reverts to the live value.
        begin_roll(1'b0);
        check("revert_value", o_value, hist_q[$]);
        check("revert_idx", o_hist_idx, 0);
        finish_roll(1'b0);

        // Roll 5 with a random restart point; history then saturates.
        idle_gap();
        begin_roll(1'b0);
        c = $urandom_range(1, 319);
        wait_until(roll_base + c);
        abort_roll(c, 1'b0);
        begin_roll(1'b0);
        finish_roll(1'b0);
        check("hist_saturated", o_hist_count, 4);
        for (int k = 0; k < 5; k++) browse_step(k % hist_cnt());

        // Reset in the middle of a roll.
        begin_roll(1'b0);
        wait_until(roll_base + 150);
        check("busy_before_reset", o_busy, 1);
        abort_roll(150, 1'b1);
        roll_active = 1'b0;
        hist_q.delete();
        i_rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        check("post_reset_hist_count", o_hist_count, 0);
        check("post_reset_busy", o_busy, 0);
        i_prev = 1'b1;
        tick();
        i_prev = 1'b0;
        tick();
        check("post_reset_prev_idx", o_hist_idx, 0);
        check("post_reset_prev_value", o_value, 0);
        check("post_reset_prev_busy", o_busy, 0);

        check("steps_outstanding", step_q.size(), 0);
        check("dones_outstanding", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
